// File: rtl/n163_ram_sched_pkg.sv
// n163_pkg: constants and types shared by the N163 sound-RAM scheduler.
package n163_pkg;

  localparam int         N163_SLOT_CPU_CYCLES = 15;
  localparam logic [6:0] N163_REG_CHCFG       = 7'h7F;
  localparam logic [4:0] N163_ADDR_PORT       = 5'b11111;  // F800-FFFF
  localparam logic [4:0] N163_DATA_PORT       = 5'b01001;  // 4800-4FFF

  typedef enum logic [1:0] {GNT_NONE, GNT_CPUWR, GNT_PREF, GNT_MIX} gnt_t;

endpackage

// File: rtl/n163_ram_sched_slot_timer.sv
// n163_slot_timer: counts CPU cycles per channel slot and rotates the
// active channel from 7 down to 7-nch.
module n163_slot_timer
  import n163_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [2:0] nch,
  output logic [2:0] ch_slot,
  output logic       ch_start,
  output logic       ch_last
);

  localparam logic [3:0] CNT_MAX = 4'(N163_SLOT_CPU_CYCLES - 1);

  logic [3:0] cnt;
  logic [2:0] last_slot;

  assign last_slot = 3'd7 - nch;
  assign ch_last   = (ch_slot == last_slot);

  // Slot timer and channel rotation; a slot already below the new last
  // channel (nch shrank mid-rotation) returns to 7 at the next wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      ch_slot  <= 3'd7;
      ch_start <= 1'b0;
    end else begin
      ch_start <= 1'b0;
      if (ce) begin
        if (cnt == CNT_MAX) begin
          cnt      <= 4'd0;
          ch_start <= 1'b1;
          ch_slot  <= (ch_slot <= last_slot) ? 3'd7 : ch_slot - 3'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/n163_ram_sched.sv
// n163_ram_sched: CPU/mixer access scheduler for the N163 128x8 sound RAM.
// Optional feature: define N163_SNDRAM_READ_EN to add the CPU read buffer
// with automatic prefetch of addr_reg.
module n163_ram_sched
  import n163_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_oe,
  input  logic        mix_req,
  input  logic [6:0]  mix_addr,
  output logic        mix_gnt,
  output logic        mix_valid,
  output logic [7:0]  mix_rdata,
  output logic [2:0]  ch_slot,
  output logic        ch_start,
  output logic        ch_last,
  output logic [6:0]  ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  logic [6:0] addr_reg;
  logic       autoinc;
  logic [2:0] nch;
  logic       wr_pend;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       pref_pend;
  gnt_t       gnt, gnt_q;

  logic addr_port_wr, data_port_wr, data_port_rd, data_acc;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[10:0];

  assign addr_port_wr = ce & cpu_wr & (cpu_addr[15:11] == N163_ADDR_PORT);
  assign data_port_wr = ce & cpu_wr & (cpu_addr[15:11] == N163_DATA_PORT);
  assign data_port_rd = ce & cpu_rd & (cpu_addr[15:11] == N163_DATA_PORT);
  assign data_acc     = data_port_wr | data_port_rd;

  // Fixed-priority arbiter: CPU write, then prefetch, then mixer.
  always_comb begin
    gnt = GNT_NONE;
    if (reset)          gnt = GNT_NONE;
    else if (wr_pend)   gnt = GNT_CPUWR;
    else if (pref_pend) gnt = GNT_PREF;
    else if (mix_req)   gnt = GNT_MIX;
  end

  // RAM port mux driven by the winning requester.
  always_comb begin
    ram_addr  = 7'h00;
    ram_wdata = 8'h00;
    case (gnt)
      GNT_CPUWR: begin
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
      end
      GNT_PREF: ram_addr = addr_reg;
      GNT_MIX:  ram_addr = mix_addr;
      default:  ram_addr = 7'h00;
    endcase
  end

  assign ram_we    = (gnt == GNT_CPUWR);
  assign mix_gnt   = (gnt == GNT_MIX);
  assign mix_valid = (gnt_q == GNT_MIX);
  assign mix_rdata = mix_valid ? ram_rdata : 8'h00;

  // CPU port decode, address register, pending write and nch snoop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= 7'h00;
      autoinc  <= 1'b0;
      nch      <= 3'd0;
      wr_pend  <= 1'b0;
      wr_addr  <= 7'h00;
      wr_data  <= 8'h00;
      gnt_q    <= GNT_NONE;
    end else begin
      gnt_q <= gnt;
      if (gnt == GNT_CPUWR) begin
        wr_pend <= 1'b0;
        if (wr_addr == N163_REG_CHCFG) nch <= wr_data[6:4];
      end
      if (addr_port_wr) begin
        autoinc  <= cpu_din[7];
        addr_reg <= cpu_din[6:0];
      end else if (data_acc) begin
        if (data_port_wr) begin
          wr_pend <= 1'b1;
          wr_addr <= addr_reg;
          wr_data <= cpu_din;
        end
        if (autoinc) addr_reg <= addr_reg + 7'd1;
      end
    end
  end

`ifdef N163_SNDRAM_READ_EN
  logic [7:0] rd_buf;
  logic       addr_chg;

  assign addr_chg = addr_port_wr | (data_acc & autoinc);

  // Read buffer: refetched whenever addr_reg moves; a write landing on the
  // current address overrides any older prefetch data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pref_pend <= 1'b0;
      rd_buf    <= 8'h00;
    end else begin
      if (gnt == GNT_PREF) pref_pend <= 1'b0;
      if (addr_chg)        pref_pend <= 1'b1;
      if (gnt_q == GNT_PREF) rd_buf <= ram_rdata;
      if (gnt == GNT_CPUWR && wr_addr == addr_reg) rd_buf <= wr_data;
    end
  end

  assign cpu_dout_oe = data_port_rd & ~reset;
  assign cpu_dout    = cpu_dout_oe ? rd_buf : 8'h00;
`else
  assign pref_pend   = 1'b0;
  assign cpu_dout_oe = 1'b0;
  assign cpu_dout    = 8'h00;
`endif

  n163_slot_timer u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .nch      (nch),
    .ch_slot  (ch_slot),
    .ch_start (ch_start),
    .ch_last  (ch_last)
  );

endmodule

// File: tb/tb_n163_ram_sched.sv
// Testbench for n163_ram_sched: directed CPU sequence, RAM model, scoreboards
// for CPU writes, mixer fetches and channel-slot starts.
module tb_n163_ram_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_oe;
  logic        mix_req = 1'b0;
  logic [6:0]  mix_addr = 7'h00;
  logic        mix_gnt, mix_valid;
  logic [7:0]  mix_rdata;
  logic [2:0]  ch_slot;
  logic        ch_start, ch_last;
  logic [6:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  n163_ram_sched dut (
    .clk(clk), .reset(reset), .ce(ce), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_dout_oe(cpu_dout_oe), .mix_req(mix_req), .mix_addr(mix_addr),
    .mix_gnt(mix_gnt), .mix_valid(mix_valid), .mix_rdata(mix_rdata),
    .ch_slot(ch_slot), .ch_start(ch_start), .ch_last(ch_last),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External 128x8 single-port RAM, registered read.
  logic [7:0] mem [128] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards and reference state.
  logic [14:0] wq[$];   // {addr, data} of expected RAM writes
  logic [7:0]  mq[$];   // expected mixer data
  logic [3:0]  sq[$];   // {slot, last} expected at each ch_start
  logic [6:0]  m_addr = 7'h00;
  logic        m_autoinc = 1'b0;
  logic [2:0]  m_nch = 3'd0;
  logic [2:0]  m_slot = 3'd7;
  int          m_cnt = 0;
  logic        m_start = 1'b0;
  logic        exp_we = 1'b0;
  logic        prev_gnt = 1'b0;
  int          n_start = 0;

  // Cycle monitor: compare outputs against the reference, then advance it
  // with this cycle's inputs.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ram_we", ram_we, 0);
      check("rst_mix_gnt", mix_gnt, 0);
      check("rst_mix_valid", mix_valid, 0);
      check("rst_ch_start", ch_start, 0);
      check("rst_cpu_dout_oe", cpu_dout_oe, 0);
      check("rst_cpu_dout", cpu_dout, 0);
      check("rst_ch_slot", ch_slot, 7);
      m_cnt = 0; m_slot = 3'd7; m_start = 1'b0; m_nch = 3'd0;
      exp_we = 1'b0; prev_gnt = 1'b0;
      wq.delete(); mq.delete(); sq.delete();
    end else begin
      check("ch_start", ch_start, m_start);
      if (ch_start) begin
        n_start++;
        if (sq.size() == 0) check("slot_sb_empty", 1, 0);
        else begin
          logic [3:0] s;
          s = sq.pop_front();
          check("ch_slot", ch_slot, s[3:1]);
          check("ch_last", ch_last, s[0]);
        end
      end
      check("ram_we", ram_we, exp_we);
      if (ram_we) begin
        check("gnt_during_write", mix_gnt, 0);
        if (wq.size() == 0) check("write_sb_empty", 1, 0);
        else begin
          logic [14:0] w;
          w = wq.pop_front();
          check("wr_addr", ram_addr, w[14:8]);
          check("wr_data", ram_wdata, w[7:0]);
          if (w[14:8] == 7'h7F) m_nch = w[6:4];
        end
      end
`ifndef N163_SNDRAM_READ_EN
      check("mix_gnt", mix_gnt, mix_req && !exp_we);
      check("cpu_dout_oe", cpu_dout_oe, 0);
      check("cpu_dout", cpu_dout, 0);
`else
      check("cpu_dout_oe", cpu_dout_oe, ce && cpu_rd && (cpu_addr[15:11] == 5'b01001));
`endif
      check("mix_valid", mix_valid, prev_gnt);
      if (mix_valid) begin
        if (mq.size() == 0) check("mix_sb_empty", 1, 0);
        else check("mix_rdata", mix_rdata, mq.pop_front());
      end
      if (mix_gnt) begin
        check("mix_ram_addr", ram_addr, mix_addr);
        mq.push_back(mem[mix_addr]);
      end
      prev_gnt = mix_gnt;
      exp_we  = ce && cpu_wr && (cpu_addr[15:11] == 5'b01001);
      m_start = 1'b0;
      if (ce) begin
        if (m_cnt == 14) begin
          m_cnt   = 0;
          m_start = 1'b1;
          m_slot  = (m_slot <= 3'd7 - m_nch) ? 3'd7 : m_slot - 3'd1;
          sq.push_back({m_slot, m_slot == 3'd7 - m_nch});
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic cpu_cyc(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d);
    ce = 1'b1; cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_din = d;
    @(posedge clk); #1;
    ce = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic addr_write(input logic [7:0] d);
    m_autoinc = d[7];
    m_addr    = d[6:0];
    cpu_cyc(1'b1, 1'b0, 16'hF800, d);
  endtask

  task automatic data_write(input logic [7:0] d);
    wq.push_back({m_addr, d});
    if (m_autoinc) m_addr = m_addr + 7'd1;
    cpu_cyc(1'b1, 1'b0, 16'h4800, d);
  endtask

  task automatic data_read(input logic [7:0] exp_d);
    ce = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h4800;
    @(negedge clk);
`ifdef N163_SNDRAM_READ_EN
    check("rd_oe", cpu_dout_oe, 1);
    check("rd_data", cpu_dout, exp_d);
`else
    check("rd_oe", cpu_dout_oe, 0);
    check("rd_data", cpu_dout, {8'h00, exp_d} >> 8);
`endif
    @(posedge clk); #1;
    ce = 1'b0; cpu_rd = 1'b0;
    if (m_autoinc) m_addr = m_addr + 7'd1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic ce_only(input int n);
    repeat (n) cpu_cyc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    int s0;
    logic found;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Mixer streams continuously while CPU traffic lands.
    mix_req = 1'b1; mix_addr = 7'd0;

    // Autoincrement writes.
    addr_write(8'h80);
    data_write(8'h11); data_write(8'h22); data_write(8'h33);
    check("ram0", mem[0], 8'h11);
    check("ram1", mem[1], 8'h22);
    check("ram2", mem[2], 8'h33);
    data_write(8'h44);
    check("ram3_addr_reg3", mem[3], 8'h44);

    // Read port.
    mix_addr = 7'd2;
    addr_write(8'h85);
    data_write(8'hA5); data_write(8'h5A);
    addr_write(8'h85);
    data_read(8'hA5);
    data_read(8'h5A);
    data_write(8'h77);
    check("ram7_after_reads", mem[7], 8'h77);
    check("ram5", mem[5], 8'hA5);

    // Rotation with nch=0, then nch=7.
    mix_addr = 7'd5;
    ce_only(20);
    addr_write(8'h7F);
    data_write(8'h70);
    check("chcfg_written", mem[127], 8'h70);
    s0 = n_start;
    ce_only(135);
    check("starts_in_135_ce", 16'(n_start - s0), 9);

    // Shrink nch while below the new last channel.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_slot == 3'd3) found = 1'b1;
      else ce_only(1);
    end
    check("reach_slot3", found, 1);
    data_write(8'h20);
    ce_only(40);
    mix_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Reset one clk after a data-port write ce.
    addr_write(8'h10);
    ce = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h4800; cpu_din = 8'hEE;
    @(posedge clk); #1;
    ce = 1'b0; cpu_wr = 1'b0;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    m_addr = 7'h00; m_autoinc = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("rst_write_dropped", mem[16], 8'h00);
    check("post_rst_slot", ch_slot, 7);

    check("write_sb_drained", 16'(wq.size()), 0);
    check("mix_sb_drained", 16'(mq.size()), 0);
    check("slot_sb_drained", 16'(sq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
